// File: rtl/i2c_slave_rsp.sv
// I2C register-file responder: 7-bit address, pointer byte, N_REGS x 8-bit registers.
// Bus inputs are synchronized to Clk; SDA is driven open-drain through SDA_oe.
module i2c_slave_rsp #(
    parameter logic [6:0] SLAVE_ADR = 7'b1001101,
    parameter int         N_REGS    = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_oe,
    output logic       Busy,
    output logic       Error,
    output logic       Wr_strobe,
    output logic [3:0] Wr_idx,
    output logic [7:0] Wr_data
);
    localparam int PW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [7:0] N_REGS_B = 8'(N_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADR, PTR, ACK_PTR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, NACK_WAIT
    } state_t;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, cnt_n;
    logic [7:0]    shreg, sh_n;
    logic [PW-1:0] ptr, ptr_n;
    logic          ptr_valid, pv_n;
    logic          rw, rw_n;
    logic          oe_n, busy_n, err_n, stb_n;
    logic [3:0]    idx_n;
    logic [7:0]    wdat_n;

    logic [7:0]    regs [N_REGS];
    logic          reg_we;
    logic [PW-1:0] reg_wa;
    logic [7:0]    reg_wd;
    logic [7:0]    byte_in, rd_byte;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            {scl_s1, scl_s2, scl_h} <= '1;
            {sda_s1, sda_s2, sda_h} <= '1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= SDA_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign byte_in   = {shreg[6:0], sda_s2};
    assign rd_byte   = regs[ptr];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            ptr_valid <= 1'b0;
            rw        <= 1'b0;
            SDA_oe    <= 1'b0;
            Busy      <= 1'b0;
            Error     <= 1'b0;
            Wr_strobe <= 1'b0;
            Wr_idx    <= '0;
            Wr_data   <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            shreg     <= sh_n;
            ptr       <= ptr_n;
            ptr_valid <= pv_n;
            rw        <= rw_n;
            SDA_oe    <= oe_n;
            Busy      <= busy_n;
            Error     <= err_n;
            Wr_strobe <= stb_n;
            Wr_idx    <= idx_n;
            Wr_data   <= wdat_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[reg_wa] <= reg_wd;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        pv_n    = ptr_valid;
        rw_n    = rw;
        oe_n    = SDA_oe;
        busy_n  = Busy;
        err_n   = Error;
        stb_n   = 1'b0;
        idx_n   = Wr_idx;
        wdat_n  = Wr_data;
        reg_we  = 1'b0;
        reg_wa  = ptr;
        reg_wd  = byte_in;

        if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            err_n   = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            pv_n    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (byte_in[7:1] == SLAVE_ADR) begin
                                state_n = ACK_ADR;
                                busy_n  = 1'b1;
                                rw_n    = byte_in[0];
                            end else begin
                                state_n = IDLE;
                                busy_n  = 1'b0;
                                pv_n    = 1'b0;
                            end
                        end
                    end
                end
                // ACK states: first SCL fall asserts the ACK, second fall ends the ACK bit.
                ACK_ADR, ACK_PTR, ACK_WR: begin
                    if (scl_fall) begin
                        if (!SDA_oe) begin
                            oe_n = 1'b1;
                        end else begin
                            oe_n  = 1'b0;
                            cnt_n = '0;
                            if (state != ACK_ADR) begin
                                state_n = WR_DATA;
                            end else if (rw) begin
                                state_n = RD_DATA;
                                sh_n    = rd_byte;
                                oe_n    = ~rd_byte[7];
                            end else if (ptr_valid) begin
                                state_n = WR_DATA;
                            end else begin
                                state_n = PTR;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (byte_in < N_REGS_B) begin
                                ptr_n   = byte_in[PW-1:0];
                                pv_n    = 1'b1;
                                state_n = ACK_PTR;
                            end else begin
                                err_n   = 1'b1;
                                state_n = NACK_WAIT;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            reg_we  = 1'b1;
                            stb_n   = 1'b1;
                            idx_n   = 4'(ptr);
                            wdat_n  = byte_in;
                            ptr_n   = ptr + PW'(1);
                            state_n = ACK_WR;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = RD_ACK;
                        end else begin
                            sh_n = {shreg[6:0], 1'b0};
                            oe_n = ~shreg[6];
                        end
                    end
                end
                // bit_cnt==1 marks a master ACK seen; pointer already advanced at that rise.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr_n = ptr + PW'(1);
                            cnt_n = 4'd1;
                        end else begin
                            state_n = NACK_WAIT;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n = RD_DATA;
                        sh_n    = rd_byte;
                        oe_n    = ~rd_byte[7];
                        cnt_n   = '0;
                    end
                end
                NACK_WAIT: ;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_rsp.sv
// Bench for i2c_slave_rsp: bit-banged I2C master, register-file model, strobe scoreboard.
module tb_i2c_slave_rsp;
    localparam int T = 6;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       SCL = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       SDA_oe, Busy, Error, Wr_strobe;
    logic [3:0] Wr_idx;
    logic [7:0] Wr_data;

    assign sda_line = sda_m & ~SDA_oe;

    i2c_slave_rsp #(.SLAVE_ADR(7'b1001101), .N_REGS(4)) dut (
        .Clk(Clk), .Rst(Rst), .SCL(SCL), .SDA_in(sda_line), .SDA_oe(SDA_oe),
        .Busy(Busy), .Error(Error), .Wr_strobe(Wr_strobe), .Wr_idx(Wr_idx), .Wr_data(Wr_data)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    logic [7:0]  mregs [4];
    int          mptr = 0;
    logic [11:0] stb_q [$];
    int          oe_rise_hi = 0;
    bit          oe_seen = 0, busy_seen = 0;
    logic        oe_prev = 1'b0;

    always @(negedge Clk) begin
        if (Wr_strobe) stb_q.push_back({Wr_idx, Wr_data});
        if (SDA_oe) oe_seen = 1;
        if (Busy) busy_seen = 1;
        if (SDA_oe && !oe_prev && SCL) oe_rise_hi++;
        oe_prev = SDA_oe;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic i2c_start();
        wt(T); sda_m = 1'b1; wt(T); SCL = 1'b1; wt(T); sda_m = 1'b0; wt(T); SCL = 1'b0;
    endtask

    task automatic i2c_stop();
        wt(T); sda_m = 1'b0; wt(T); SCL = 1'b1; wt(T); sda_m = 1'b1; wt(T);
    endtask

    task automatic send_bit(input logic b);
        wt(T); sda_m = b; wt(T); SCL = 1'b1; wt(2 * T); SCL = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output int ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wt(T); sda_m = 1'b1; wt(T); SCL = 1'b1; wt(T);
        ack = (sda_line == 1'b0) ? 1 : 0;
        wt(T); SCL = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wt(2 * T); SCL = 1'b1; wt(T); b = sda_line; wt(T); SCL = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] v, input bit mack);
        logic b;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            v = {v[6:0], b};
        end
        wt(T); sda_m = mack ? 1'b0 : 1'b1; wt(T); SCL = 1'b1; wt(2 * T); SCL = 1'b0;
        wt(T); sda_m = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mptr = 0;
    endtask

    // Full write transaction; model applies the data bytes at the pointer with wrap.
    task automatic do_write(input logic [7:0] p, input int n, input logic [31:0] d,
                            input int exp_ack, input int exp_nstb);
        int a;
        logic [7:0] b;
        logic [11:0] exp_q [$];
        stb_q.delete();
        i2c_start();
        write_byte(8'h9A, a);
        chk("adr_ack", a, 1);
        chk("busy_after_adr", int'(Busy), 1);
        write_byte(p, a);
        chk("ptr_ack", a, exp_ack);
        if (a == 1) begin
            mptr = int'(p);
            for (int i = 0; i < n; i++) begin
                b = d[31 - 8 * i -: 8];
                write_byte(b, a);
                chk("data_ack", a, 1);
                exp_q.push_back({mptr[3:0], b});
                mregs[mptr] = b;
                mptr = (mptr + 1) % 4;
            end
        end else begin
            chk("error_flag", int'(Error), 1);
        end
        i2c_stop();
        wt(2);
        chk("busy_after_stop", int'(Busy), 0);
        chk("stb_count", stb_q.size(), exp_nstb);
        chk("stb_count_model", stb_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
            chk("stb_entry", int'(stb_q[i]), int'(exp_q[i]));
    endtask

    // Set pointer, repeated START, read n bytes (ACK all but the last).
    task automatic read_check(input logic [7:0] p, input int n);
        int a;
        logic [7:0] v;
        i2c_start();
        write_byte(8'h9A, a);
        chk("rd_adr_ack", a, 1);
        write_byte(p, a);
        chk("rd_ptr_ack", a, 1);
        mptr = int'(p);
        i2c_start();
        write_byte(8'h9B, a);
        chk("rd_adr2_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(v, i < n - 1);
            chk("rd_data", int'(v), int'(mregs[mptr]));
            if (i < n - 1) mptr = (mptr + 1) % 4;
        end
        wt(T);
        chk("rd_released", int'(SDA_oe), 0);
        i2c_stop();
    endtask

    typedef struct {
        logic [7:0]  ptr;
        int          nbytes;
        logic [31:0] data;
        int          exp_ack;
        int          exp_nstb;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int a, n, ea;
        logic [7:0] p, v;
        logic b;

        vecs[0] = '{8'h01, 1, 32'h9900_0000, 1, 1};
        vecs[1] = '{8'h02, 2, 32'h9931_0000, 1, 2};
        vecs[2] = '{8'h02, 3, 32'h9931_5500, 1, 3};
        vecs[3] = '{8'h07, 0, 32'h0000_0000, 0, 0};
        vecs[4] = '{8'h04, 1, 32'hAA00_0000, 0, 0};
        vecs[5] = '{8'h03, 1, 32'h1200_0000, 1, 1};
        vecs[6] = '{8'h00, 4, 32'hA1B2_C3D4, 1, 4};

        model_reset();
        Rst = 1'b1;
        wt(4);
        chk("rst_sda_oe", int'(SDA_oe), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_error", int'(Error), 0);
        chk("rst_wr_strobe", int'(Wr_strobe), 0);
        chk("rst_wr_idx", int'(Wr_idx), 0);
        chk("rst_wr_data", int'(Wr_data), 0);
        Rst = 1'b0;
        wt(T);

        foreach (vecs[k])
            do_write(vecs[k].ptr, vecs[k].nbytes, vecs[k].data, vecs[k].exp_ack, vecs[k].exp_nstb);
        read_check(8'h00, 4);

        // Read 0x99 then 0x31 from reg2/reg3 with master ACK then NACK.
        do_write(8'h02, 2, 32'h9931_0000, 1, 2);
        read_check(8'h02, 2);

        // Pointer persists across STOP: pointer-only write, then a plain read.
        i2c_start(); write_byte(8'h9A, a); write_byte(8'h01, a); i2c_stop();
        chk("ptr_only_ack", a, 1);
        i2c_start(); write_byte(8'h9B, a); read_byte(v, 1'b0); i2c_stop();
        chk("persist_ptr_read", int'(v), int'(mregs[1]));

        // Wrong address: never ACK, never busy.
        oe_seen = 0; busy_seen = 0; stb_q.delete();
        i2c_start(); write_byte(8'h98, a); write_byte(8'h55, n); i2c_stop();
        chk("bad_adr_ack", a, 0);
        chk("bad_adr_oe_seen", int'(oe_seen), 0);
        chk("bad_adr_busy_seen", int'(busy_seen), 0);
        chk("bad_adr_no_stb", stb_q.size(), 0);

        // Out-of-range pointer: Error sticky past STOP, cleared by next START.
        i2c_start(); write_byte(8'h9A, a); write_byte(8'h07, a);
        chk("ptr7_nack", a, 0);
        i2c_stop();
        chk("error_sticky", int'(Error), 1);
        i2c_start(); wt(4);
        chk("error_cleared", int'(Error), 0);
        i2c_stop();

        // START in the middle of a data byte: no write, pointer unchanged.
        stb_q.delete();
        i2c_start(); write_byte(8'h9A, a); write_byte(8'h02, a);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        i2c_start(); write_byte(8'h9B, a); read_byte(v, 1'b0); i2c_stop();
        chk("abort_no_stb", stb_q.size(), 0);
        chk("abort_ptr_kept", int'(v), int'(mregs[2]));

        for (int r = 0; r < 12; r++) begin
            p = 8'($urandom_range(0, 5));
            n = $urandom_range(1, 3);
            ea = (p < 8'd4) ? 1 : 0;
            do_write(p, n, $urandom(), ea, ea * n);
            if (r % 4 == 3) read_check(8'h00, 4);
        end

        // Reset while the responder drives a 0 data bit.
        do_write(8'h00, 4, 32'h005A_A5FF, 1, 4);
        i2c_start(); write_byte(8'h9A, a); write_byte(8'h00, a);
        i2c_start(); write_byte(8'h9B, a);
        for (int i = 0; i < 4; i++) recv_bit(b);
        wt(T);
        chk("rd_drive_before_rst", int'(SDA_oe), 1);
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;
        chk("rst_mid_oe", int'(SDA_oe), 0);
        chk("rst_mid_busy", int'(Busy), 0);
        SCL = 1'b1; sda_m = 1'b1;
        wt(3); Rst = 1'b0; model_reset(); wt(T);
        read_check(8'h00, 4);

        // Reset mid data-write after 4 bits, then a normal write.
        stb_q.delete();
        i2c_start(); write_byte(8'h9A, a); write_byte(8'h01, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;
        chk("rst_wr_oe", int'(SDA_oe), 0);
        SCL = 1'b1; wt(2); sda_m = 1'b1;
        wt(3); Rst = 1'b0; model_reset(); wt(T);
        chk("rst_wr_no_stb", stb_q.size(), 0);
        do_write(8'h01, 2, 32'h3C7E_0000, 1, 2);
        read_check(8'h00, 4);

        chk("oe_rise_while_scl_high", oe_rise_hi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_slave_rsp.md
I2C_SLAVE_RSP -- requirements
Module: i2c_slave_rsp

Interface
REQ-001 The block SHALL have parameter SLAVE_ADR, default 7'b1001101, meaning the 7-bit address this responder answers to.
REQ-002 The block SHALL have parameter N_REGS, default 4, meaning the number of 8-bit registers (power of two, 2..16).
REQ-003 Clk  input  1  system clock; all logic on rising edge of Clk; one clock domain.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 SCL  input  1  I2C clock from the master (asynchronous to Clk).
REQ-006 SDA_in  input  1  sampled state of the SDA line (asynchronous to Clk).
REQ-007 SDA_oe  output  1  open-drain pull-down enable; 1 = drive SDA low, 0 = release.
REQ-008 Busy  output  1  high from address match until STOP or bus abort.
REQ-009 Error  output  1  sticky flag: pointer out of range; cleared at next START.
REQ-010 Wr_strobe  output  1  one-Clk pulse when a data byte is written to a register.
REQ-011 Wr_idx  output  4  register index written with Wr_strobe.
REQ-012 Wr_data  output  8  byte written with Wr_strobe.

Function
REQ-013 SCL and SDA_in SHALL each pass a 2-flop synchronizer plus one history flop; all edge and condition detection uses synchronized values.
REQ-014 START/repeated START SHALL be detected as synchronized SDA falling while SCL is high; STOP as SDA rising while SCL is high.
REQ-015 Data bits SHALL be sampled on a detected SCL rising edge, MSB first; SDA_oe SHALL change only in the Clk cycle after a detected SCL falling edge.
REQ-016 States: IDLE, ADDR, ACK_ADR, PTR, ACK_PTR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, NACK_WAIT.
REQ-017 START from any state -> ADDR, bit counter cleared; STOP from any state -> IDLE, SDA_oe=0, Busy=0.
REQ-018 ADDR: after 8 bits, if addr[7:1]==SLAVE_ADR -> ACK_ADR (SDA_oe=1 for one SCL pulse), Busy=1; else -> IDLE with SDA_oe held 0.
REQ-019 After ACK_ADR: R/W bit 0 and no pointer yet in this transaction -> PTR; R/W bit 0 after a pointer -> WR_DATA; R/W bit 1 -> RD_DATA.
REQ-020 PTR: 8 bits received; value < N_REGS -> pointer loaded, ACK_PTR ACKs, -> WR_DATA; value >= N_REGS -> no ACK, Error=1, -> NACK_WAIT (ignore until START/STOP).
REQ-021 WR_DATA: each 8-bit byte written to reg[pointer], Wr_strobe pulsed the Clk after the 8th sampled bit, ACKed in ACK_WR, pointer increments modulo N_REGS (wrap N_REGS-1 -> 0); unlimited bytes.
REQ-022 RD_DATA: reg[pointer] loaded into shift register at entry; SDA_oe = ~bit (drive low for 0) for 8 bits; then released for RD_ACK.
REQ-023 RD_ACK: master ACK (SDA low) -> pointer increments with wrap, -> RD_DATA; master NACK -> NACK_WAIT, SDA released.
REQ-024 Pointer SHALL persist across transactions (a write of pointer only, then repeated START read, reads from that pointer).
REQ-025 SCL stretching SHALL NOT be performed; SDA_oe SHALL never assert while SCL is high except when holding an ACK/data bit across that high phase.
REQ-026 A START arriving mid-byte SHALL abort the byte with no register write and no pointer change.

Reset
REQ-027 While Rst=1 at a Clk edge: state=IDLE, SDA_oe=0, Busy=0, Error=0, Wr_strobe=0, Wr_idx=0, Wr_data=0, pointer=0, all registers=8'h00, synchronizer flops=1 (idle bus).
REQ-028 Reset mid-transfer SHALL release SDA within the same Clk edge; the block resumes only on a fresh START after Rst falls.

Verification
REQ-029 START, 0x9A (adr 1001101 + W), ptr 0x01, data 0x99, STOP -> three ACKs, Wr_strobe once with Wr_idx=1, Wr_data=0x99.
REQ-030 START, 0x9A, ptr 0x02, 0x99, 0x31, STOP -> reg2=0x99, reg3=0x31; further byte 0x55 wraps to reg0.
REQ-031 START, 0x9A, ptr 0x02, repeated START, 0x9B, master ACK then NACK -> slave drives 0x99 then 0x31 on SDA, then releases.
REQ-032 START, 0x98 (adr 1001100) -> no ACK, SDA_oe stays 0 for whole transfer, Busy stays 0.
REQ-033 START, 0x9A, ptr 0x07 -> NACK on pointer, Error=1, no Wr_strobe; next START clears Error.
REQ-034 Rst=1 asserted mid data byte after 4 bits -> SDA_oe=0 and registers 0x00 next edge; a full write sequence after Rst completes normally.
